// File: rtl/mem_access.sv
// Memory stage: RV32I loads/stores over a single-outstanding req/ack bus,
// with lane steering, load extension, fault and bus-timeout reporting.
module mem_access #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  dest_i,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [4:0]  wb_dest,
   output logic [31:0] wb_data,
   output logic        fault,
   output logic        timeout
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          ld_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [4:0]    dest_q;

   logic        accept, is_mem, ld, legal_f3, aligned, ok;
   logic [3:0]  be_c;
   logic [31:0] wd_c, rd_sh, ld_val;

   assign busy    = (state == WAIT);
   assign mem_req = (state == WAIT);
   assign accept  = (state == IDLE) && in_valid;
   assign is_mem  = is_load | is_store;
   assign ld      = is_load;
   assign ok      = legal_f3 && aligned;

   always_comb begin
      legal_f3 = 1'b0;
      aligned  = 1'b1;
      be_c     = 4'b1111;
      wd_c     = store_data;
      if (ld)
         legal_f3 = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010)
                 || (func3 == 3'b100) || (func3 == 3'b101);
      else
         legal_f3 = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
      unique case (func3[1:0])
         2'b00: begin
            be_c = 4'b0001 << addr[1:0];
            wd_c = {4{store_data[7:0]}};
         end
         2'b01: begin
            aligned = !addr[0];
            be_c    = addr[1] ? 4'b1100 : 4'b0011;
            wd_c    = {2{store_data[15:0]}};
         end
         default: aligned = (addr[1:0] == 2'b00);
      endcase
      if (ld)
         wd_c = 32'h0;
   end

   // half accesses are aligned, so a byte-granular shift also serves halves
   assign rd_sh = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_val = mem_rdata;
      unique case (f3_q)
         3'b000:  ld_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
         3'b001:  ld_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
         3'b100:  ld_val = {24'h0, rd_sh[7:0]};
         3'b101:  ld_val = {16'h0, rd_sh[15:0]};
         default: ld_val = mem_rdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept && is_mem && ok) state_nx = WAIT;
         WAIT: if (mem_ack || cnt == LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         ld_q      <= 1'b0;
         f3_q      <= 3'b0;
         off_q     <= 2'b0;
         dest_q    <= 5'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_be    <= 4'h0;
         mem_wdata <= 32'h0;
         wb_valid  <= 1'b0;
         wb_dest   <= 5'b0;
         wb_data   <= 32'h0;
         fault     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         fault    <= 1'b0;
         timeout  <= 1'b0;
         if (accept) begin
            if (!is_mem) begin
               wb_valid <= (dest_i != 5'd0);
               wb_dest  <= dest_i;
               wb_data  <= addr;
            end else if (!ok) begin
               fault <= 1'b1;
            end else begin
               cnt       <= '0;
               ld_q      <= ld;
               f3_q      <= func3;
               off_q     <= addr[1:0];
               dest_q    <= dest_i;
               mem_we    <= !ld;
               mem_addr  <= {addr[31:2], 2'b00};
               mem_be    <= be_c;
               mem_wdata <= wd_c;
            end
         end else if (state == WAIT) begin
            if (mem_ack) begin
               cnt <= '0;
               if (ld_q && dest_q != 5'd0) begin
                  wb_valid <= 1'b1;
                  wb_dest  <= dest_q;
                  wb_data  <= ld_val;
               end
            end else if (cnt == LAST) begin
               cnt     <= '0;
               timeout <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level model
// that predicts every output cycle by cycle.
module tb_mem_access;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, is_load, is_store;
   logic [2:0]  func3;
   logic [31:0] addr, store_data;
   logic [4:0]  dest_i;
   logic        busy, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        wb_valid;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        fault, timeout;

   mem_access #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .is_load(is_load),
      .is_store(is_store), .func3(func3), .addr(addr),
      .store_data(store_data), .dest_i(dest_i), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_dest(wb_dest),
      .wb_data(wb_data), .fault(fault), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;
   bit pinned = 1'b0;

   logic        e_busy, e_we, e_wbv, e_fault, e_to;
   logic [31:0] e_addr, e_wd, e_wbdat;
   logic [3:0]  e_be;
   logic [4:0]  e_wbd;

   function automatic logic m_legal(logic ld, logic [2:0] f, logic [31:0] a);
      logic ok;
      if (ld) ok = f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      else    ok = f inside {3'd0, 3'd1, 3'd2};
      if (f[1:0] == 2'd1 && a[0]) ok = 1'b0;
      if (f[1:0] == 2'd2 && a[1:0] != 2'd0) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [3:0] m_be(logic [2:0] f, logic [31:0] a);
      int o;
      o = int'(a[1:0]);
      if (f[1:0] == 2'd0) return 4'(1 << o);
      if (f[1:0] == 2'd1) return (o >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wd(logic [2:0] f, logic [31:0] sd);
      if (f[1:0] == 2'd0) return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      if (f[1:0] == 2'd1) return {sd[15:0], sd[15:0]};
      return sd;
   endfunction

   function automatic logic [31:0] m_load(logic [2:0] f, logic [1:0] a, logic [31:0] rd);
      logic [7:0] by [4];
      logic [7:0] b;
      logic [15:0] h;
      int o;
      for (int i = 0; i < 4; i++) by[i] = rd[8*i +: 8];
      o = int'(a);
      b = by[o];
      h = {by[(o | 1)], by[o & 2]};
      case (f)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd4:    return {24'h0, b};
         3'd5:    return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   task automatic pin(string nm, logic [31:0] got, logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL pin %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic cmp(string nm, logic [31:0] got, logic [31:0] want);
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!pinned) begin
         pinned = 1'b1;
         pin("lb_203", m_load(3'd0, 2'd3, 32'h80FFFF12), 32'hFFFFFF80);
         pin("lbu_203", m_load(3'd4, 2'd3, 32'h80FFFF12), 32'h00000080);
         pin("lhu_202", m_load(3'd5, 2'd2, 32'h80FFFF12), 32'h000080FF);
         pin("sh_be", {28'h0, m_be(3'd1, 32'h102)}, 32'hC);
         pin("sh_wd", m_wd(3'd1, 32'h1234ABCD), 32'hABCDABCD);
         pin("sb_be", {28'h0, m_be(3'd0, 32'h101)}, 32'h2);
         pin("lw_101", {31'h0, m_legal(1'b1, 3'd2, 32'h101)}, 32'h0);
      end
      if (chk_en) begin
         vectors++;
         cmp("busy", {31'h0, busy}, {31'h0, e_busy});
         cmp("mem_req", {31'h0, mem_req}, {31'h0, e_busy});
         cmp("wb_valid", {31'h0, wb_valid}, {31'h0, e_wbv});
         cmp("fault", {31'h0, fault}, {31'h0, e_fault});
         cmp("timeout", {31'h0, timeout}, {31'h0, e_to});
         if (e_busy) begin
            cmp("mem_we", {31'h0, mem_we}, {31'h0, e_we});
            cmp("mem_addr", mem_addr, e_addr);
            cmp("mem_be", {28'h0, mem_be}, {28'h0, e_be});
            cmp("mem_wdata", mem_wdata, e_wd);
         end
         if (e_wbv) begin
            cmp("wb_dest", {27'h0, wb_dest}, {27'h0, e_wbd});
            cmp("wb_data", wb_data, e_wbdat);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_idle();
      e_busy = 0; e_we = 0; e_addr = 0; e_be = 0; e_wd = 0;
      e_wbv = 0; e_wbd = 0; e_wbdat = 0; e_fault = 0; e_to = 0;
   endtask

   task automatic junk_inputs();
      in_valid   = 1'($urandom);
      is_load    = 1'($urandom);
      is_store   = 1'($urandom);
      func3      = 3'($urandom);
      addr       = $urandom;
      store_data = $urandom;
      dest_i     = 5'($urandom);
   endtask

   // one instruction from presentation until the stage is idle again
   task automatic op(logic ld, logic st, logic [2:0] f, logic [31:0] a,
                     logic [31:0] sd, logic [4:0] d, int lat, logic [31:0] rd);
      int n;
      logic lod;
      lod = ld;
      exp_idle();
      in_valid = 1; is_load = ld; is_store = st; func3 = f;
      addr = a; store_data = sd; dest_i = d;
      mem_ack = 1'($urandom);
      mem_rdata = $urandom;
      tick();
      mem_ack = 0;
      if (!ld && !st) begin
         in_valid = 0;
         e_wbv = (d != 0); e_wbd = d; e_wbdat = a;
         tick();
      end else if (!m_legal(lod, f, a)) begin
         in_valid = 0;
         e_fault = 1;
         tick();
      end else begin
         n = (lat >= 1 && lat <= T) ? lat : T;
         for (int k = 1; k <= n; k++) begin
            junk_inputs();
            e_busy = 1; e_we = !lod; e_addr = {a[31:2], 2'b00};
            e_be = m_be(f, a); e_wd = lod ? 32'h0 : m_wd(f, sd);
            mem_ack = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            tick();
         end
         exp_idle();
         in_valid = 0; mem_ack = 0;
         if (lat >= 1 && lat <= T) begin
            if (lod && d != 0) begin
               e_wbv = 1; e_wbd = d; e_wbdat = m_load(f, a[1:0], rd);
            end
         end else begin
            e_to = 1;
         end
         tick();
      end
      exp_idle();
   endtask

   initial begin
      logic ld, st;
      exp_idle();
      reset = 1; in_valid = 0; is_load = 0; is_store = 0; func3 = 0;
      addr = 0; store_data = 0; dest_i = 0; mem_rdata = 0; mem_ack = 0;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      reset = 0;
      tick();

      op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd7, 3, 32'h0);
      op(1, 0, 3'd0, 32'h203, 32'h0, 5'd5, 1, 32'h80FFFF12);
      op(1, 0, 3'd4, 32'h203, 32'h0, 5'd6, 2, 32'h80FFFF12);
      op(1, 0, 3'd5, 32'h202, 32'h0, 5'd8, 1, 32'h80FFFF12);
      op(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 5'd1, 1, 32'h0);
      op(0, 1, 3'd0, 32'h101, 32'h000000A5, 5'd1, 2, 32'h0);
      op(1, 0, 3'd2, 32'h101, 32'h0, 5'd9, 1, 32'h0);
      op(0, 0, 3'd0, 32'h55, 32'h0, 5'd3, 0, 32'h0);
      op(1, 0, 3'd2, 32'h40, 32'h0, 5'd4, 0, 32'h0);
      op(1, 1, 3'd2, 32'h44, 32'h9, 5'd10, 4, 32'hCAFEF00D);
      op(1, 0, 3'd2, 32'h48, 32'h0, 5'd0, 1, 32'h12345678);

      // reset in the middle of a pending store
      exp_idle();
      in_valid = 1; is_load = 0; is_store = 1; func3 = 3'd2;
      addr = 32'h300; store_data = 32'h11; dest_i = 5'd2;
      tick();
      in_valid = 0;
      e_busy = 1; e_we = 1; e_addr = 32'h300; e_be = 4'hF; e_wd = 32'h11;
      tick();
      reset = 1;
      tick();
      exp_idle();
      reset = 0;
      tick();

      for (int i = 0; i < 400; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         ld = (kind == 1 || kind == 3);
         st = (kind == 2 || kind == 3);
         op(ld, st, 3'($urandom), ($urandom_range(0, 3) == 0) ? $urandom :
            {$urandom & 32'hFFFFFFFC} | 32'($urandom_range(0, 3) == 0 ? 2 : 0),
            $urandom, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
            $urandom_range(0, T + 2), $urandom);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
